// File: rtl/pe_feeder.sv
// Operand feeder for a 3-tap multiply-accumulate PE: streams 3*num_ch kernel-row
// beats into the PE, framing each accumulation with a clear (PE_en) and a final-beat flag.
module pe_feeder #(
  parameter int CH_W = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            abort,
  input  logic [CH_W-1:0] num_ch,
  input  logic            din_valid,
  input  logic [23:0]     din_ifm,
  input  logic [23:0]     din_w,
  output logic            din_ready,
  output logic [7:0]      IFM1,
  output logic [7:0]      IFM2,
  output logic [7:0]      IFM3,
  output logic [7:0]      Weight1,
  output logic [7:0]      Weight2,
  output logic [7:0]      Weight3,
  output logic            PE_en,
  output logic            PE_finish,
  output logic            busy,
  output logic            done,
  output logic [1:0]      state_dbg
);

  // Handshake: a beat transfers on a rising edge where din_valid and din_ready
  // are both 1; din_ready is registered and never depends on din_valid.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Target width covers 3*num_ch for any CH_W; the beat counter itself is 10 bits.
  localparam int TW = (CH_W + 2 > 10) ? CH_W + 2 : 10;

  state_t          state_q, state_d;
  logic [9:0]      cnt_q, cnt_d;
  logic [TW-1:0]   target_q, target_d;
  logic [CH_W-1:0] nch_eff;
  logic            accept, last_beat;

  logic            ready_d, pe_en_d, finish_d, done_d;
  logic [23:0]     ifm_d, w_d;

  assign nch_eff   = (num_ch == '0) ? CH_W'(1) : num_ch;
  assign accept    = (state_q == ST_RUN) && din_valid && din_ready;
  assign last_beat = ((TW'(cnt_q) + TW'(1)) == target_q);

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      target_q  <= '0;
      din_ready <= 1'b0;
      PE_en     <= 1'b1;
      PE_finish <= 1'b0;
      done      <= 1'b0;
      IFM1      <= '0;
      IFM2      <= '0;
      IFM3      <= '0;
      Weight1   <= '0;
      Weight2   <= '0;
      Weight3   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      target_q  <= target_d;
      din_ready <= ready_d;
      PE_en     <= pe_en_d;
      PE_finish <= finish_d;
      done      <= done_d;
      IFM1      <= ifm_d[7:0];
      IFM2      <= ifm_d[15:8];
      IFM3      <= ifm_d[23:16];
      Weight1   <= w_d[7:0];
      Weight2   <= w_d[15:8];
      Weight3   <= w_d[23:16];
    end
  end

  // Next-state and beat bookkeeping.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d  = ST_RUN;
          cnt_d    = '0;
          target_d = TW'({nch_eff, 1'b0}) + TW'(nch_eff);
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (accept) begin
          cnt_d = cnt_q + 10'd1;
          if (last_beat) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Values the output registers take at the next edge.
  always_comb begin
    ready_d  = 1'b0;
    pe_en_d  = 1'b1;
    finish_d = 1'b0;
    done_d   = 1'b0;
    ifm_d    = '0;
    w_d      = '0;
    case (state_q)
      ST_IDLE: begin
        // Entering RUN keeps PE_en high one more cycle so the PE clears.
        if (start && !abort) ready_d = 1'b1;
      end
      ST_RUN: begin
        if (!abort) begin
          pe_en_d = 1'b0;
          ready_d = 1'b1;
          if (accept) begin
            ifm_d = din_ifm;
            w_d   = din_w;
            if (last_beat) begin
              finish_d = 1'b1;
              ready_d  = 1'b0;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (!abort) done_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_pe_feeder.sv
// Directed bench for pe_feeder: drives kernel-row beats, checks every PE-facing
// output cycle by cycle and checks the sum seen by an attached accumulator.
module tb_pe_feeder;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic       clk = 1'b0;
  logic       reset_n, start, abort, din_valid;
  logic [7:0] num_ch;
  logic [23:0] din_ifm, din_w;
  logic       din_ready, PE_en, PE_finish, busy, done;
  logic [7:0] IFM1, IFM2, IFM3, Weight1, Weight2, Weight3;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int finish_cnt = 0;
  int done_cnt   = 0;

  pe_feeder #(.CH_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .num_ch(num_ch), .din_valid(din_valid), .din_ifm(din_ifm), .din_w(din_w),
    .din_ready(din_ready),
    .IFM1(IFM1), .IFM2(IFM2), .IFM3(IFM3),
    .Weight1(Weight1), .Weight2(Weight2), .Weight3(Weight3),
    .PE_en(PE_en), .PE_finish(PE_finish), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Attached PE: clears on PE_en, accumulates otherwise, presents OFM after PE_finish.
  int  pe_acc = 0;
  int  pe_ofm = 0;
  logic pe_valid = 1'b0;
  int  prod;
  assign prod = int'(IFM1) * int'(Weight1) + int'(IFM2) * int'(Weight2) + int'(IFM3) * int'(Weight3);

  always @(posedge clk) begin
    pe_valid <= 1'b0;
    if (PE_en === 1'b1) begin
      pe_acc <= 0;
    end else begin
      pe_acc <= pe_acc + prod;
      if (PE_finish === 1'b1) begin
        pe_ofm   <= pe_acc + prod;
        pe_valid <= 1'b1;
      end
    end
    if (PE_finish === 1'b1) finish_cnt <= finish_cnt + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic rdy, input logic en, input logic fin,
                            input logic dn, input logic [1:0] st,
                            input logic [23:0] ifm, input logic [23:0] w);
    check({tag, ".din_ready"}, 32'(din_ready), 32'(rdy));
    check({tag, ".PE_en"}, 32'(PE_en), 32'(en));
    check({tag, ".PE_finish"}, 32'(PE_finish), 32'(fin));
    check({tag, ".done"}, 32'(done), 32'(dn));
    check({tag, ".state"}, 32'(state_dbg), 32'(st));
    check({tag, ".busy"}, 32'(busy), 32'(st != S_IDLE));
    check({tag, ".ifm"}, 32'({IFM3, IFM2, IFM1}), 32'(ifm));
    check({tag, ".w"}, 32'({Weight3, Weight2, Weight1}), 32'(w));
  endtask

  // Driver tasks
  task automatic start_job(input string tag, input logic [7:0] nch);
    start  = 1'b1;
    num_ch = nch;
    tick();
    start = 1'b0;
    check_outs({tag, ".start"}, 1'b1, 1'b1, 1'b0, 1'b0, S_RUN, 24'h0, 24'h0);
  endtask

  task automatic beat(input string tag, input logic [23:0] ifm, input logic [23:0] w,
                      input logic last, input logic do_abort);
    din_valid = 1'b1;
    din_ifm   = ifm;
    din_w     = w;
    abort     = do_abort;
    tick();
    din_valid = 1'b0;
    abort     = 1'b0;
    if (do_abort)
      check_outs({tag, ".abort"}, 1'b0, 1'b1, 1'b0, 1'b0, S_IDLE, 24'h0, 24'h0);
    else if (last)
      check_outs({tag, ".last"}, 1'b0, 1'b0, 1'b1, 1'b0, S_DRAIN, ifm, w);
    else
      check_outs({tag, ".beat"}, 1'b1, 1'b0, 1'b0, 1'b0, S_RUN, ifm, w);
  endtask

  task automatic gap(input string tag, input int n);
    din_valid = 1'b0;
    din_ifm   = 24'hDEAD55;
    din_w     = 24'h7777AA;
    for (int i = 0; i < n; i++) begin
      tick();
      check_outs({tag, ".gap"}, 1'b1, 1'b0, 1'b0, 1'b0, S_RUN, 24'h0, 24'h0);
    end
  endtask

  task automatic finish_job(input string tag, input int exp_sum);
    tick();
    check_outs({tag, ".done"}, 1'b0, 1'b1, 1'b0, 1'b1, S_IDLE, 24'h0, 24'h0);
    check({tag, ".pe_valid"}, 32'(pe_valid), 32'd1);
    check({tag, ".ofm"}, 32'(pe_ofm), 32'(exp_sum));
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b1; abort = 1'b0; din_valid = 1'b0;
    num_ch = 8'd1; din_ifm = '0; din_w = '0;

    // Reset held two cycles with start asserted
    tick(); tick();
    check_outs("reset", 1'b0, 1'b1, 1'b0, 1'b0, S_IDLE, 24'h0, 24'h0);
    reset_n = 1'b1; start = 1'b0;
    tick();
    check_outs("post_reset", 1'b0, 1'b1, 1'b0, 1'b0, S_IDLE, 24'h0, 24'h0);

    // abort alone and abort+start in IDLE stay in IDLE
    abort = 1'b1;
    tick();
    check_outs("idle_abort", 1'b0, 1'b1, 1'b0, 1'b0, S_IDLE, 24'h0, 24'h0);
    start = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check_outs("idle_start_abort", 1'b0, 1'b1, 1'b0, 1'b0, S_IDLE, 24'h0, 24'h0);

    // Job A: one channel, (1+2+3)*1 per beat -> 18
    start_job("A", 8'd1);
    beat("A1", 24'h030201, 24'h010101, 1'b0, 1'b0);
    beat("A2", 24'h030201, 24'h010101, 1'b0, 1'b0);
    beat("A3", 24'h030201, 24'h010101, 1'b1, 1'b0);
    finish_job("A", 18);
    tick();

    // Job B: two channels, 2-cycle stall after beat 3; 6+12+510+12+96+0 = 636
    start_job("B", 8'd2);
    beat("B1", 24'h030201, 24'h010101, 1'b0, 1'b0);
    beat("B2", 24'h0A0B0C, 24'h000001, 1'b0, 1'b0);
    beat("B3", 24'hFF0000, 24'h020000, 1'b0, 1'b0);
    gap("B", 2);
    beat("B4", 24'h000400, 24'h000300, 1'b0, 1'b0);
    beat("B5", 24'h101010, 24'h010203, 1'b0, 1'b0);
    beat("B6", 24'h808080, 24'h000000, 1'b1, 1'b0);
    finish_job("B", 636);

    // Job C: num_ch=0 behaves as 1; 3 beats of 5*2*3 = 30 -> 90
    start_job("C", 8'd0);
    beat("C1", 24'h050505, 24'h020202, 1'b0, 1'b0);
    beat("C2", 24'h050505, 24'h020202, 1'b0, 1'b0);
    beat("C3", 24'h050505, 24'h020202, 1'b1, 1'b0);
    finish_job("C", 90);

    // Job D: abort after two beats with a beat in flight, then job E is clean
    start_job("D", 8'd2);
    beat("D1", 24'h090909, 24'h090909, 1'b0, 1'b0);
    beat("D2", 24'h090909, 24'h090909, 1'b0, 1'b0);
    beat("D3", 24'h090909, 24'h090909, 1'b0, 1'b1);
    tick();
    check_outs("D_after", 1'b0, 1'b1, 1'b0, 1'b0, S_IDLE, 24'h0, 24'h0);
    start_job("E", 8'd1);
    beat("E1", 24'h030201, 24'h010101, 1'b0, 1'b0);
    beat("E2", 24'h030201, 24'h010101, 1'b0, 1'b0);
    beat("E3", 24'h030201, 24'h010101, 1'b1, 1'b0);
    finish_job("E", 18);

    // Job F: abort coincides with the last beat; abort wins
    start_job("F", 8'd1);
    beat("F1", 24'h111111, 24'h010101, 1'b0, 1'b0);
    beat("F2", 24'h111111, 24'h010101, 1'b0, 1'b0);
    beat("F3", 24'h111111, 24'h010101, 1'b0, 1'b1);
    tick();
    check_outs("F_after", 1'b0, 1'b1, 1'b0, 1'b0, S_IDLE, 24'h0, 24'h0);

    // Job G: start pulsed mid-RUN is ignored; start on the done cycle launches job H
    start_job("G", 8'd1);
    start = 1'b1; num_ch = 8'd5;
    beat("G1", 24'h030201, 24'h010101, 1'b0, 1'b0);
    start = 1'b0;
    beat("G2", 24'h030201, 24'h010101, 1'b0, 1'b0);
    beat("G3", 24'h030201, 24'h010101, 1'b1, 1'b0);
    finish_job("G", 18);
    start_job("H", 8'd1);
    beat("H1", 24'h000102, 24'h040404, 1'b0, 1'b0);
    beat("H2", 24'h000102, 24'h040404, 1'b0, 1'b0);
    beat("H3", 24'h000102, 24'h040404, 1'b1, 1'b0);
    finish_job("H", 36);

    // Reset mid-RUN drops the job silently
    start_job("R", 8'd1);
    beat("R1", 24'h030201, 24'h010101, 1'b0, 1'b0);
    reset_n = 1'b0; din_valid = 1'b1; start = 1'b1; abort = 1'b1;
    tick();
    din_valid = 1'b0; start = 1'b0; abort = 1'b0;
    check_outs("mid_reset", 1'b0, 1'b1, 1'b0, 1'b0, S_IDLE, 24'h0, 24'h0);
    reset_n = 1'b1;
    tick(); tick();
    check_outs("mid_reset_after", 1'b0, 1'b1, 1'b0, 1'b0, S_IDLE, 24'h0, 24'h0);

    // Six completed jobs: A, B, C, E, G, H
    check("finish_pulses", 32'(finish_cnt), 32'd6);
    check("done_pulses", 32'(done_cnt), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
